// File: rtl/ro_pair_meter_if.sv
// Start/busy/done handshake and result bus of the ring-oscillator pair meter.
// The master issues challenges; the slave (the meter) returns counts and flags.
interface ro_pair_meter_if #(
    parameter int SEL_W = 3,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic [SEL_W-1:0] chal_a;
    logic [SEL_W-1:0] chal_b;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic             resp;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             tie;
    logic             sat;
    logic             err;

    modport master (
        output start,
        output chal_a,
        output chal_b,
        output win_len,
        input  busy,
        input  done,
        input  resp,
        input  cnt_a,
        input  cnt_b,
        input  tie,
        input  sat,
        input  err
    );

    modport slave (
        input  start,
        input  chal_a,
        input  chal_b,
        input  win_len,
        output busy,
        output done,
        output resp,
        output cnt_a,
        output cnt_b,
        output tie,
        output sat,
        output err
    );
endinterface

// File: rtl/ro_pair_meter.sv
// Ring-oscillator PUF measurement core: enables two challenged rings, counts
// their synchronised rising edges over a window and compares the counts.
module ro_pair_meter #(
    parameter int NUM_RO     = 8,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en,
    ro_pair_meter_if.slave    bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_COUNT   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] SET_LAST = WIN_W'(SETTLE_CYC - 1);

    logic [2:0]        r_state;
    logic [WIN_W-1:0]  r_tmr;
    logic [WIN_W-1:0]  r_win;
    logic              r_cmp_ph;
    logic [NUM_RO-1:0] r_sel_a;
    logic [NUM_RO-1:0] r_sel_b;
    logic [NUM_RO-1:0] r_en;
    logic [2:0]        r_sync_a;
    logic [2:0]        r_sync_b;
    logic [CNT_W-1:0]  r_cnt_a;
    logic [CNT_W-1:0]  r_cnt_b;
    logic [CNT_W-1:0]  r_out_a;
    logic [CNT_W-1:0]  r_out_b;
    logic              r_resp;
    logic              r_tie;
    logic              r_sat;
    logic              r_err;

    logic [NUM_RO-1:0] w_dec_a;
    logic [NUM_RO-1:0] w_dec_b;
    logic              w_legal;
    logic              w_ro_a;
    logic              w_ro_b;
    logic              w_edge_a;
    logic              w_edge_b;
    logic              w_cnt_last;

    // One-hot decode doubles as the range check: an index >= NUM_RO decodes to zero.
    always_comb begin
        w_dec_a = '0;
        w_dec_b = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            w_dec_a[i] = (bus.chal_a == SEL_W'(i));
            w_dec_b[i] = (bus.chal_b == SEL_W'(i));
        end
    end

    assign w_legal = (|w_dec_a) && (|w_dec_b) && (bus.chal_a != bus.chal_b);

    assign w_ro_a = |(ro_in & r_sel_a);
    assign w_ro_b = |(ro_in & r_sel_b);

    // Two synchroniser flops plus one history flop for the edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[1:0], w_ro_a};
            r_sync_b <= {r_sync_b[1:0], w_ro_b};
        end
    end

    assign w_edge_a = r_sync_a[1] & ~r_sync_a[2];
    assign w_edge_b = r_sync_b[1] & ~r_sync_b[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (r_state == S_SETTLE) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (r_state == S_COUNT) begin
            if (w_edge_a && (r_cnt_a != CNT_MAX)) begin
                r_cnt_a <= r_cnt_a + CNT_W'(1);
            end
            if (w_edge_b && (r_cnt_b != CNT_MAX)) begin
                r_cnt_b <= r_cnt_b + CNT_W'(1);
            end
        end
    end

    assign w_cnt_last = (r_tmr == (r_win - WIN_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tmr    <= '0;
            r_win    <= '0;
            r_cmp_ph <= 1'b0;
            r_sel_a  <= '0;
            r_sel_b  <= '0;
            r_en     <= '0;
            r_out_a  <= '0;
            r_out_b  <= '0;
            r_resp   <= 1'b0;
            r_tie    <= 1'b0;
            r_sat    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_win   <= bus.win_len;
                        r_tmr   <= '0;
                        r_out_a <= '0;
                        r_out_b <= '0;
                        r_resp  <= 1'b0;
                        r_tie   <= 1'b0;
                        r_sat   <= 1'b0;
                        if (w_legal) begin
                            r_sel_a <= w_dec_a;
                            r_sel_b <= w_dec_b;
                            r_en    <= w_dec_a | w_dec_b;
                            r_err   <= 1'b0;
                            r_state <= S_SETTLE;
                        end else begin
                            r_sel_a <= '0;
                            r_sel_b <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_tmr == SET_LAST) begin
                        r_tmr <= '0;
                        if (r_win == '0) begin
                            r_en    <= '0;
                            r_state <= S_COMPARE;
                        end else begin
                            r_state <= S_COUNT;
                        end
                    end else begin
                        r_tmr <= r_tmr + WIN_W'(1);
                    end
                end
                S_COUNT: begin
                    if (w_cnt_last) begin
                        r_tmr   <= '0;
                        r_en    <= '0;
                        r_state <= S_COMPARE;
                    end else begin
                        r_tmr <= r_tmr + WIN_W'(1);
                    end
                end
                S_COMPARE: begin
                    // Capture the counts first, then derive flags from the
                    // registered copies so the comparator sees stable values.
                    if (!r_cmp_ph) begin
                        r_out_a  <= r_cnt_a;
                        r_out_b  <= r_cnt_b;
                        r_cmp_ph <= 1'b1;
                    end else begin
                        r_resp   <= (r_out_a > r_out_b);
                        r_tie    <= (r_out_a == r_out_b);
                        r_sat    <= (r_out_a == CNT_MAX) || (r_out_b == CNT_MAX);
                        r_cmp_ph <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ro_en     = r_en;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.resp  = r_resp;
    assign bus.cnt_a = r_out_a;
    assign bus.cnt_b = r_out_b;
    assign bus.tie   = r_tie;
    assign bus.sat   = r_sat;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_ro_pair_meter.sv
// Directed bench for ro_pair_meter: synthetic rings driven from a cycle
// counter, one task per scenario with inline expected-value checks.
module tb_ro_pair_meter;

    localparam int NUM_RO = 8;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 8;
    localparam int WIN_W  = 16;
    localparam int S      = 4;

    logic              clk;
    logic              rst;
    logic [NUM_RO-1:0] ro_in;
    logic [NUM_RO-1:0] ro_en;

    int checks;
    int errors;
    int cyc;
    int per [NUM_RO];

    ro_pair_meter_if #(.SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    ro_pair_meter #(
        .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W),
        .WIN_W(WIN_W), .SETTLE_CYC(S)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ro_in(ro_in),
        .ro_en(ro_en),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rings only oscillate while enabled; equal periods are phase-aligned.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < NUM_RO; i++) begin
            if (per[i] == 0) ro_in[i] = 1'b0;
            else ro_in[i] = ro_en[i] && ((cyc % per[i]) < (per[i] / 2));
        end
    end

    task automatic run(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b,
                       input int w, input int poke,
                       output int dcyc, output logic hs_ok);
        logic [NUM_RO-1:0] m;
        logic [NUM_RO-1:0] exp_en;
        bit legal;
        legal = (a < NUM_RO) && (b < NUM_RO) && (a != b);
        m = '0;
        if (legal) begin
            m[a[2:0]] = 1'b1;
            m[b[2:0]] = 1'b1;
        end
        @(negedge clk);
        bus.chal_a  = a;
        bus.chal_b  = b;
        bus.win_len = WIN_W'(w);
        bus.start   = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dcyc  = -1;
        hs_ok = 1'b1;
        for (int n = 1; n <= w + 50; n++) begin
            @(negedge clk);
            if (n == poke) begin
                bus.start  = 1'b1;
                bus.chal_a = 4'd7;
                bus.chal_b = 4'd7;
            end else begin
                bus.start = 1'b0;
            end
            exp_en = (legal && n <= S + w) ? m : '0;
            if (ro_en !== exp_en || bus.busy !== 1'b1) hs_ok = 1'b0;
            if (bus.done === 1'b1) begin
                dcyc = n;
                break;
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || ro_en !== '0) hs_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ro_en, bus.busy, bus.done, bus.resp, bus.cnt_a, bus.cnt_b,
             bus.tie, bus.sat, bus.err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b busy=%b done=%b cnt=%0d/%0d want all 0",
                     ro_en, bus.busy, bus.done, bus.cnt_a, bus.cnt_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int d;
        logic ok;
        logic [CNT_W-1:0] held;
        per[2] = 10;
        per[5] = 12;
        run(4'd2, 4'd5, 1200, 0, d, ok);
        checks++;
        if (d !== 1207) begin
            errors++;
            $display("FAIL basic_done_cycle got %0d want 1207", d);
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake got %b want 1", ok);
        end
        checks++;
        if (bus.cnt_a < 119 || bus.cnt_a > 121 || bus.cnt_b < 99 || bus.cnt_b > 101) begin
            errors++;
            $display("FAIL basic_counts got %0d/%0d want 120/100", bus.cnt_a, bus.cnt_b);
        end
        checks++;
        if ({bus.resp, bus.tie, bus.err, bus.sat} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_flags got %b want 1000",
                     {bus.resp, bus.tie, bus.err, bus.sat});
        end
        held = bus.cnt_a;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.cnt_a !== held || bus.resp !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold got %0d want %0d", bus.cnt_a, held);
        end
    endtask

    task automatic test_swap;
        int d;
        logic ok;
        run(4'd5, 4'd2, 1200, 0, d, ok);
        checks++;
        if (bus.resp !== 1'b0 || bus.cnt_a < 99 || bus.cnt_a > 101 ||
            bus.cnt_b < 119 || bus.cnt_b > 121 || !ok) begin
            errors++;
            $display("FAIL swap got resp=%b cnt=%0d/%0d want 0 100/120",
                     bus.resp, bus.cnt_a, bus.cnt_b);
        end
    endtask

    task automatic test_tie;
        int d;
        logic ok;
        per[1] = 8;
        per[6] = 8;
        run(4'd1, 4'd6, 800, 0, d, ok);
        checks++;
        if (bus.cnt_a !== 8'd100 || bus.cnt_b !== 8'd100 ||
            bus.tie !== 1'b1 || bus.resp !== 1'b0 || d !== 807) begin
            errors++;
            $display("FAIL tie got %0d/%0d tie=%b resp=%b d=%0d want 100/100 1 0 807",
                     bus.cnt_a, bus.cnt_b, bus.tie, bus.resp, d);
        end
        run(4'd1, 4'd6, 0, 0, d, ok);
        checks++;
        if (d !== 7 || bus.cnt_a !== '0 || bus.cnt_b !== '0 || bus.tie !== 1'b1 || !ok) begin
            errors++;
            $display("FAIL win_zero got d=%0d cnt=%0d/%0d tie=%b want 7 0/0 1",
                     d, bus.cnt_a, bus.cnt_b, bus.tie);
        end
    endtask

    task automatic test_illegal;
        int d;
        logic ok;
        run(4'd2, 4'd5, 300, 0, d, ok);
        run(4'd3, 4'd3, 100, 0, d, ok);
        checks++;
        if (d !== 1 || bus.err !== 1'b1 || bus.resp !== 1'b0 ||
            bus.cnt_a !== '0 || bus.cnt_b !== '0 || !ok) begin
            errors++;
            $display("FAIL illegal_same got d=%0d err=%b cnt=%0d/%0d ok=%b want 1 1 0/0 1",
                     d, bus.err, bus.cnt_a, bus.cnt_b, ok);
        end
        run(4'd9, 4'd2, 100, 0, d, ok);
        checks++;
        if (d !== 1 || bus.err !== 1'b1 || !ok) begin
            errors++;
            $display("FAIL illegal_range got d=%0d err=%b want 1 1", d, bus.err);
        end
    endtask

    task automatic test_busy_start;
        int d;
        logic ok;
        run(4'd2, 4'd5, 1200, 300, d, ok);
        checks++;
        if (d !== 1207 || bus.err !== 1'b0 || bus.resp !== 1'b1 ||
            bus.cnt_a < 119 || bus.cnt_a > 121 || bus.cnt_b < 99 || bus.cnt_b > 101 || !ok) begin
            errors++;
            $display("FAIL busy_start got d=%0d err=%b cnt=%0d/%0d want 1207 0 120/100",
                     d, bus.err, bus.cnt_a, bus.cnt_b);
        end
    endtask

    task automatic test_sat;
        int d;
        logic ok;
        per[0] = 4;
        per[7] = 10;
        run(4'd0, 4'd7, 2000, 0, d, ok);
        checks++;
        if (bus.cnt_a !== 8'd255 || bus.sat !== 1'b1 || bus.resp !== 1'b1 ||
            bus.cnt_b < 199 || bus.cnt_b > 201) begin
            errors++;
            $display("FAIL saturate got cnt=%0d/%0d sat=%b want 255/200 1",
                     bus.cnt_a, bus.cnt_b, bus.sat);
        end
    endtask

    task automatic test_reset_mid;
        int d;
        logic ok;
        logic seen_done;
        @(negedge clk);
        bus.chal_a  = 4'd2;
        bus.chal_b  = 4'd5;
        bus.win_len = 16'd1200;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ro_en !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got en=%b busy=%b want 0 0", ro_en, bus.busy);
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_done got %b want 0", seen_done);
        end
        run(4'd2, 4'd5, 600, 0, d, ok);
        checks++;
        if (d !== 607 || bus.cnt_a < 59 || bus.cnt_a > 61 ||
            bus.cnt_b < 49 || bus.cnt_b > 51 || bus.resp !== 1'b1 || !ok) begin
            errors++;
            $display("FAIL reset_recover got d=%0d cnt=%0d/%0d want 607 60/50",
                     d, bus.cnt_a, bus.cnt_b);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        for (int i = 0; i < NUM_RO; i++) per[i] = 0;
        bus.start   = 1'b0;
        bus.chal_a  = '0;
        bus.chal_b  = '0;
        bus.win_len = '0;
        test_reset();
        test_basic();
        test_swap();
        test_tie();
        test_illegal();
        test_busy_start();
        test_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
